// File: rtl/traffic_light_monitor.sv
// Protocol monitor for a two-direction traffic-light controller: checks lamp patterns,
// phase order and phase durations. Optional loop statistics under TRAFFIC_MONITOR_STATS_EN.
module traffic_light_monitor #(
  parameter int unsigned GREEN_CYCLES  = 30,
  parameter int unsigned YELLOW_CYCLES = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        r1,
  input  logic        y1,
  input  logic        g1,
  input  logic        r2,
  input  logic        y2,
  input  logic        g2,
  input  logic        clear,
  output logic [1:0]  phase,
  output logic        phase_valid,
  output logic        fault,
  output logic [2:0]  fault_code,
  output logic [7:0]  cycle_count,
  output logic [15:0] loop_count
);

  localparam logic [1:0] PH_RG = 2'd0;
  localparam logic [1:0] PH_RY = 2'd1;
  localparam logic [1:0] PH_GR = 2'd2;
  localparam logic [1:0] PH_YR = 2'd3;

  localparam logic [7:0] GREEN_LEN  = 8'(GREEN_CYCLES);
  localparam logic [7:0] YELLOW_LEN = 8'(YELLOW_CYCLES);

  // Returns {legal, phase} for a lamp vector ordered {r1, y1, g1, r2, y2, g2}.
  function automatic logic [2:0] decode(input logic [5:0] lamps);
    case (lamps)
      6'b100_001: decode = {1'b1, PH_RG};
      6'b100_010: decode = {1'b1, PH_RY};
      6'b001_100: decode = {1'b1, PH_GR};
      6'b010_100: decode = {1'b1, PH_YR};
      default:    decode = 3'b000;
    endcase
  endfunction

  logic [5:0] samp_q;
  logic [1:0] phase_q, phase_d;
  logic [7:0] cnt_q, cnt_d;
  logic       timed_q, timed_d;
  logic       fault_q, fault_d;
  logic [2:0] code_q, code_d;

  logic [2:0] in_dec, cur_dec;
  logic       in_legal, cur_valid;
  logic [1:0] in_ph;
  logic [7:0] cur_len, cnt_inc;
  logic       e1, e2, e3, e4, raise, loop_step;
  logic [2:0] new_code;

  always_comb begin
    in_dec    = decode({r1, y1, g1, r2, y2, g2});
    cur_dec   = decode(samp_q);
    in_legal  = in_dec[2];
    in_ph     = in_dec[1:0];
    cur_valid = cur_dec[2];
    cur_len   = phase_q[0] ? YELLOW_LEN : GREEN_LEN;
    cnt_inc   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
  end

  always_comb begin
    phase_d   = phase_q;
    cnt_d     = 8'd0;
    timed_d   = 1'b0;
    e1        = 1'b0;
    e2        = 1'b0;
    e3        = 1'b0;
    e4        = 1'b0;
    loop_step = 1'b0;
    if (!in_legal) begin
      e1 = 1'b1;
    end else if (cur_valid && (in_ph == phase_q)) begin
      cnt_d   = cnt_inc;
      timed_d = timed_q;
      e4      = timed_q && (cnt_inc == cur_len + 8'd1);
    end else begin
      // A phase is timed only when it follows another legal phase.
      phase_d = in_ph;
      cnt_d   = 8'd1;
      timed_d = cur_valid;
      if (cur_valid && timed_q) begin
        e2        = (in_ph != phase_q + 2'd1);
        e3        = (cnt_q < cur_len);
        loop_step = (phase_q == PH_YR) && (in_ph == PH_RG);
      end
    end
    if (clear) timed_d = 1'b0;
  end

  always_comb begin
    if (e1)      new_code = 3'd1;
    else if (e2) new_code = 3'd2;
    else if (e3) new_code = 3'd3;
    else if (e4) new_code = 3'd4;
    else         new_code = 3'd0;
    raise = e1 | e2 | e3 | e4;

    fault_d = fault_q;
    code_d  = code_q;
    if (clear) begin
      fault_d = raise;
      code_d  = new_code;
    end else if (raise && !fault_q) begin
      fault_d = 1'b1;
      code_d  = new_code;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      samp_q  <= 6'd0;
      phase_q <= PH_RG;
      cnt_q   <= 8'd0;
      timed_q <= 1'b0;
      fault_q <= 1'b0;
      code_q  <= 3'd0;
    end else begin
      samp_q  <= {r1, y1, g1, r2, y2, g2};
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      timed_q <= timed_d;
      fault_q <= fault_d;
      code_q  <= code_d;
    end
  end

`ifdef TRAFFIC_MONITOR_STATS_EN
  logic [15:0] loop_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      loop_q <= 16'd0;
    end else if (loop_step && !raise && (loop_q != 16'hFFFF)) begin
      loop_q <= loop_q + 16'd1;
    end
  end

  assign loop_count = loop_q;
`else
  logic unused_loop;
  assign unused_loop = loop_step;
  assign loop_count  = 16'h0000;
`endif

  assign phase       = phase_q;
  assign phase_valid = cur_valid;
  assign fault       = fault_q;
  assign fault_code  = code_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed-vector bench for traffic_light_monitor with default 30/5 cycle phases.
module tb_traffic_light_monitor;

  localparam logic [5:0] RG  = 6'b100_001;
  localparam logic [5:0] RY  = 6'b100_010;
  localparam logic [5:0] GR  = 6'b001_100;
  localparam logic [5:0] YR  = 6'b010_100;
  localparam logic [5:0] BAD = 6'b101_000;

`ifdef TRAFFIC_MONITOR_STATS_EN
  localparam int LOOP_ONE   = 1;
  localparam int LOOP_THREE = 3;
`else
  localparam int LOOP_ONE   = 0;
  localparam int LOOP_THREE = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        r1 = 1'b0, y1 = 1'b0, g1 = 1'b0, r2 = 1'b0, y2 = 1'b0, g2 = 1'b0;
  logic        clear = 1'b0;
  logic [1:0]  phase;
  logic        phase_valid;
  logic        fault;
  logic [2:0]  fault_code;
  logic [7:0]  cycle_count;
  logic [15:0] loop_count;

  int n_vec = 0;
  int n_err = 0;

  traffic_light_monitor dut (
    .clk         (clk),
    .reset       (reset),
    .r1          (r1),
    .y1          (y1),
    .g1          (g1),
    .r2          (r2),
    .y2          (y2),
    .g2          (g2),
    .clear       (clear),
    .phase       (phase),
    .phase_valid (phase_valid),
    .fault       (fault),
    .fault_code  (fault_code),
    .cycle_count (cycle_count),
    .loop_count  (loop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Hold a lamp pattern for n clock edges; returns 1 ns after the last edge.
  task automatic drive(input logic [5:0] p, input int n);
    {r1, y1, g1, r2, y2, g2} = p;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic [5:0] p);
    {r1, y1, g1, r2, y2, g2} = p;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    // Reset state
    {r1, y1, g1, r2, y2, g2} = GR;
    repeat (2) @(posedge clk);
    #1;
    check("rst_phase", phase, 0);
    check("rst_valid", phase_valid, 0);
    check("rst_fault", fault, 0);
    check("rst_code", fault_code, 0);
    check("rst_cnt", cycle_count, 0);
    check("rst_loop", loop_count, 0);
    reset = 1'b0;

    // Correct sequence GR31 / YR5 / RG30 / RY5 / GR30
    drive(GR, 1);
    check("seq_gr_phase", phase, 2);
    check("seq_gr_valid", phase_valid, 1);
    check("seq_gr_cnt1", cycle_count, 1);
    drive(GR, 30);
    check("seq_gr_cnt31", cycle_count, 31);
    check("seq_gr_fault", fault, 0);
    drive(YR, 5);
    check("seq_yr_phase", phase, 3);
    check("seq_yr_cnt", cycle_count, 5);
    drive(RG, 30);
    check("seq_rg_phase", phase, 0);
    check("seq_rg_fault", fault, 0);
    drive(RY, 5);
    check("seq_ry_phase", phase, 1);
    drive(GR, 30);
    check("seq_gr2_phase", phase, 2);
    check("seq_gr2_cnt", cycle_count, 30);
    check("seq_fault", fault, 0);
    check("seq_loop", loop_count, LOOP_ONE);

    // Timed RG held 31 cycles: too long
    drive(YR, 5);
    drive(RG, 30);
    check("long_pre_fault", fault, 0);
    drive(RG, 1);
    check("long_fault", fault, 1);
    check("long_code", fault_code, 4);
    check("long_cnt", cycle_count, 31);

    // Timed RY only 3 cycles: too short, then illegal keeps first code
    do_reset(RG);
    check("rst2_fault", fault, 0);
    drive(RG, 3);
    drive(RY, 3);
    check("short_pre", fault, 0);
    drive(GR, 1);
    check("short_code", fault_code, 3);
    drive(BAD, 1);
    check("bad_code", fault_code, 3);
    check("bad_valid", phase_valid, 0);
    check("bad_phase", phase, 2);
    check("bad_cnt", cycle_count, 0);

    // Timed RG (5 cycles) straight to GR: order and short both, order wins
    do_reset(RG);
    drive(RG, 2);
    drive(RY, 5);
    drive(GR, 30);
    drive(YR, 5);
    drive(RG, 5);
    check("order_pre", fault, 0);
    drive(GR, 1);
    check("order_code", fault_code, 2);
    clear = 1'b1;
    drive(GR, 1);
    clear = 1'b0;
    check("clr_fault", fault, 0);
    check("clr_code", fault_code, 0);
    check("clr_cnt", cycle_count, 2);
    drive(GR, 1);
    drive(YR, 1);
    check("clr_untimed", fault, 0);
    clear = 1'b1;
    drive(BAD, 1);
    check("clr_win_fault", fault, 1);
    check("clr_win_code", fault_code, 1);
    drive(RG, 1);
    clear = 1'b0;
    check("clr2_fault", fault, 0);
    check("clr2_code", fault_code, 0);

    // Reset in the middle of a timed GR aborts checks
    do_reset(RY);
    drive(RY, 2);
    drive(GR, 12);
    reset = 1'b1;
    #1;
    check("mid_rst_cnt", cycle_count, 0);
    check("mid_rst_valid", phase_valid, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(YR, 2);
    drive(RG, 1);
    check("mid_fault", fault, 0);
    check("mid_cnt", cycle_count, 1);
    check("mid_phase", phase, 0);

    // Three complete loops
    do_reset(RG);
    drive(RG, 1);
    for (int i = 0; i < 3; i++) begin
      drive(RY, 5);
      drive(GR, 30);
      drive(YR, 5);
      drive(RG, (i == 2) ? 1 : 30);
    end
    check("loops_fault", fault, 0);
    check("loops_count", loop_count, LOOP_THREE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
